c_shift_lane_v5_0: RTL and testbench
====================================

Name: c_shift_lane_v5_0

Overview:
- Parametrised successor to the v4 shift register.
- Each shift moves a C_LANE-bit lane rather than one bit.
- Keeps parallel load, the fill modes and bidirectional shifting.
- Adds an autonomous burst engine: shifts a programmed number of lanes with START/BUSY/DONE, for use as a serializer/deserializer in front of the OFDM bit-interleave and scrambler paths.

Parameters:
- C_WIDTH, 16, register width in bits; must be a multiple of C_LANE.
- C_LANE, 1, bits moved per shift step (1..C_WIDTH/2).
- C_SHIFT_TYPE, 0, 0=lsb_to_msb, 1=msb_to_lsb, 2=bidirectional.
- C_FILL_DATA, 5, 0=zeros, 1=ones, 2=lsb replicate, 3=msb replicate, 4=wrap, 5=sdin.
- C_SINIT_VAL, 0, value loaded by SCLR.
- C_CNT_W, derived, clog2(C_WIDTH/C_LANE)+1, width of COUNT.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- ACLR_N  in  1  asynchronous active-low reset.
- CE  in  1  clock enable; when low, all registers hold (Q, BUSY, DONE, remaining count).
- SCLR  in  1  synchronous clear to C_SINIT_VAL; aborts any burst.
- LSB_2_MSB  in  1  direction, used only when C_SHIFT_TYPE=2; 1 = towards MSB.
- P_LOAD  in  1  parallel load of D.
- D  in  C_WIDTH  parallel load data.
- SDIN  in  C_LANE  serial lane in, used when C_FILL_DATA=5.
- SHIFT  in  1  single manual shift step; honoured only when idle.
- START  in  1  begin a burst of COUNT steps.
- COUNT  in  C_CNT_W  steps in the burst.
- BUSY  out  1  burst in progress.
- DONE  out  1  one-cycle pulse when a burst completes.
- SDOUT  out  C_LANE  outgoing lane, combinational from Q.
- Q  out  C_WIDTH  register contents.

Behaviour:
- Reset: ACLR_N=0 immediately forces Q=0, BUSY=0, DONE=0, remaining=0, regardless of CLK and CE. Release is synchronous to the next edge.
- Priority when CE=1, highest first: SCLR, P_LOAD, burst step, manual SHIFT, hold.
- SCLR:
  - Q<=C_SINIT_VAL, BUSY<=0, remaining<=0, DONE<=0.
  - A START in the same cycle is ignored.
- Shift step, lsb_to_msb: Q<={Q[W-L-1:0], fill}; SDOUT=Q[W-1:W-L].
- Shift step, msb_to_lsb: Q<={fill, Q[W-1:L]}; SDOUT=Q[L-1:0].
- Bidirectional: direction is taken from LSB_2_MSB, sampled each step; SDOUT follows the current LSB_2_MSB.
- Fill values:
  - zeros: all 0.
  - ones: all 1.
  - lsb: {L{Q[0]}}.
  - msb: {L{Q[W-1]}} (arithmetic right shift).
  - wrap: the outgoing lane, i.e. a rotate.
  - sdin: SDIN.
- Burst FSM, states IDLE and RUN:
  - IDLE + START: latch remaining<=min(COUNT, C_WIDTH/L); go to RUN, BUSY=1 from the next cycle.
  - IDLE + START with COUNT=0: stay IDLE; DONE=1 next cycle; Q unchanged.
  - RUN: each CE cycle performs one shift and decrements remaining.
  - RUN, step with remaining=1: go to IDLE, BUSY<=0, DONE<=1 in the same edge.
  - Total latency from START to DONE is N+1 cycles for N steps.
- Burst edge cases:
  - START while RUN is ignored; SHIFT while RUN is ignored.
  - P_LOAD while RUN: Q<=D, burst aborted (BUSY<=0, remaining<=0), no DONE.
  - P_LOAD and START together in IDLE: Q<=D and remaining latched in the same edge; shifting starts the following cycle (load-and-serialize).
- DONE is high for exactly one CE-qualified cycle. When CE is low it holds its value.
- Manual SHIFT in IDLE: exactly one step; no DONE.

Decomposition:
- Package c_shift_pkg holds:
  - shift-type constants (c_lsb_to_msb, c_msb_to_lsb, c_bidirectional);
  - fill constants (c_zeros through c_sdin);
  - a clog2 function used to derive C_CNT_W.
- One sub-module, c_shift_burst_ctl: the IDLE/RUN FSM plus the remaining-count down-counter, producing BUSY, DONE and step_en.
- The datapath (fill select, lane shift, load mux) stays in the top level.

Test Plan:
- Reset: W=16, L=1. Load 16'hA5A5, then assert ACLR_N=0 mid-burst → Q=0, BUSY=0, DONE=0 immediately, with no clock required.
- Serialize: W=16, L=4, lsb_to_msb, zeros. P_LOAD=1 and START=1 with D=16'h1234, COUNT=4 → Q=16'h1234, then SDOUT=1,2,3,4 on the four step cycles; Q=0 afterwards; DONE pulses at cycle 5, and BUSY is high for cycles 1–4 only.
- Wrap and count clamp: W=8, L=2, msb_to_lsb, wrap. D=8'hC6, START with COUNT=1 → Q=8'hB1. Then START with COUNT=15 → clamped to 4 steps, Q returns to 8'hB1.
- Arithmetic fill: W=8, L=1, msb_to_lsb, msb. D=8'h90, three manual SHIFTs → Q=8'hF2; BUSY and DONE stay low.
- Abort and CE: start a COUNT=4 burst; drop CE for 2 cycles → Q, BUSY and remaining frozen. Then P_LOAD with D=8'h0F → Q=8'h0F, BUSY=0, no DONE. START with COUNT=0 → DONE pulses once and Q is unchanged.
- Bidirectional SDIN: W=8, L=2, type 2, sdin, Q=0. SDIN=2'b11 with LSB_2_MSB=1, then SDIN=2'b01 with LSB_2_MSB=0 → Q=8'h03 after step 1, then 8'h40 after step 2.

Source files
------------

// File: rtl/c_shift_pkg.sv
// Shared constants for the lane shift register family: shift directions,
// fill modes and a constant-foldable ceiling log2.
package c_shift_pkg;

  localparam int c_lsb_to_msb    = 0;
  localparam int c_msb_to_lsb    = 1;
  localparam int c_bidirectional = 2;

  localparam int c_zeros = 0;
  localparam int c_ones  = 1;
  localparam int c_lsb   = 2;
  localparam int c_msb   = 3;
  localparam int c_wrap  = 4;
  localparam int c_sdin  = 5;

  // Smallest r with 2**r >= value; loop stops at 30 so 1<<i stays positive.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/c_shift_burst_ctl.sv
// Burst sequencer: IDLE/RUN state plus a down-counter of remaining lane steps.
// Emits step_en on every enabled RUN cycle and a one-cycle DONE at the end.
module c_shift_burst_ctl #(
  parameter int C_STEPS = 16,
  parameter int C_CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic               sclr,
  input  logic               p_load,
  input  logic               start,
  input  logic [C_CNT_W-1:0] count,
  output logic               busy,
  output logic               done,
  output logic               step_en
);

  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;
  localparam logic [C_CNT_W-1:0] MAX_STEPS = C_CNT_W'(C_STEPS);

  logic               state_reg;
  logic               done_reg;
  logic [C_CNT_W-1:0] remaining_reg;
  logic [C_CNT_W-1:0] clamped;

  assign clamped = (count > MAX_STEPS) ? MAX_STEPS : count;
  assign busy    = (state_reg == RUN);
  assign done    = done_reg;
  // Clear and load outrank a burst step, so they also suppress it here.
  assign step_en = ce & ~sclr & ~p_load & (state_reg == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      done_reg      <= 1'b0;
    end else if (ce) begin
      done_reg <= 1'b0;
      if (sclr) begin
        state_reg     <= IDLE;
        remaining_reg <= '0;
      end else if (state_reg == RUN) begin
        if (p_load) begin
          state_reg     <= IDLE;
          remaining_reg <= '0;
        end else begin
          remaining_reg <= remaining_reg - 1'b1;
          if (remaining_reg == C_CNT_W'(1)) begin
            state_reg <= IDLE;
            done_reg  <= 1'b1;
          end
        end
      end else if (start) begin
        // A zero-length burst completes immediately without entering RUN.
        if (count == '0) begin
          done_reg <= 1'b1;
        end else begin
          remaining_reg <= clamped;
          state_reg     <= RUN;
        end
      end
    end
  end

endmodule

// File: rtl/c_shift_lane_v5_0.sv
// Lane-wide shift register with parallel load, selectable fill and an
// autonomous burst engine for serialize/deserialize use.
module c_shift_lane_v5_0
  import c_shift_pkg::*;
#(
  parameter int                 C_WIDTH      = 16,
  parameter int                 C_LANE       = 1,
  parameter int                 C_SHIFT_TYPE = 0,
  parameter int                 C_FILL_DATA  = 5,
  parameter logic [C_WIDTH-1:0] C_SINIT_VAL  = '0,
  parameter int                 C_CNT_W      = clog2(C_WIDTH / C_LANE) + 1
) (
  input  logic               CLK,
  input  logic               ACLR_N,
  input  logic               CE,
  input  logic               SCLR,
  input  logic               LSB_2_MSB,
  input  logic               P_LOAD,
  input  logic [C_WIDTH-1:0] D,
  input  logic [C_LANE-1:0]  SDIN,
  input  logic               SHIFT,
  input  logic               START,
  input  logic [C_CNT_W-1:0] COUNT,
  output logic               BUSY,
  output logic               DONE,
  output logic [C_LANE-1:0]  SDOUT,
  output logic [C_WIDTH-1:0] Q
);

  localparam int STEPS = C_WIDTH / C_LANE;

  logic               dir_up;
  logic               busy_int;
  logic               step_en;
  logic               step;
  logic [C_LANE-1:0]  out_lane;
  logic [C_LANE-1:0]  fill;
  logic [C_WIDTH-1:0] shifted;
  logic [C_WIDTH-1:0] q_reg;

  c_shift_burst_ctl #(
    .C_STEPS (STEPS),
    .C_CNT_W (C_CNT_W)
  ) u_burst_ctl (
    .clk     (CLK),
    .rst_n   (ACLR_N),
    .ce      (CE),
    .sclr    (SCLR),
    .p_load  (P_LOAD),
    .start   (START),
    .count   (COUNT),
    .busy    (busy_int),
    .done    (DONE),
    .step_en (step_en)
  );

  always_comb begin
    dir_up = 1'b1;
    if (C_SHIFT_TYPE == c_msb_to_lsb)         dir_up = 1'b0;
    else if (C_SHIFT_TYPE == c_bidirectional) dir_up = LSB_2_MSB;
  end

  assign out_lane = dir_up ? q_reg[C_WIDTH-1 -: C_LANE] : q_reg[C_LANE-1:0];

  always_comb begin
    case (C_FILL_DATA)
      c_zeros: fill = '0;
      c_ones:  fill = '1;
      c_lsb:   fill = {C_LANE{q_reg[0]}};
      c_msb:   fill = {C_LANE{q_reg[C_WIDTH-1]}};
      c_wrap:  fill = out_lane;
      default: fill = SDIN;
    endcase
  end

  assign shifted = dir_up ? {q_reg[C_WIDTH-C_LANE-1:0], fill}
                          : {fill, q_reg[C_WIDTH-1:C_LANE]};

  // Manual steps are only honoured while no burst owns the register.
  assign step = step_en | (SHIFT & ~busy_int);

  always_ff @(posedge CLK or negedge ACLR_N) begin
    if (!ACLR_N) begin
      q_reg <= '0;
    end else if (CE) begin
      if (SCLR)        q_reg <= C_SINIT_VAL;
      else if (P_LOAD) q_reg <= D;
      else if (step)   q_reg <= shifted;
    end
  end

  assign Q     = q_reg;
  assign SDOUT = out_lane;
  assign BUSY  = busy_int;

endmodule

// File: tb/tb_c_shift_lane_v5_0.sv
// Drives five differently-configured instances from one shared stimulus and
// compares each against an arithmetic reference model every clock.
module tb_c_shift_lane_v5_0;

  logic        clk = 1'b0;
  logic        aclr_n, ce, sclr, lsb2msb, pload, shift, start;
  logic [15:0] d;
  logic [3:0]  sdin;
  logic [4:0]  cnt;

  wire  [15:0] q0, q4;
  wire  [7:0]  q1, q2, q3;
  wire  [3:0]  s0;
  wire  [1:0]  s1, s3;
  wire         s2, s4;
  wire  [4:0]  busy, done;

  // Instance configuration: width, lane, shift type, fill, COUNT width, SCLR value.
  int          pw[5]  = '{16, 8, 8, 8, 16};
  int          pl[5]  = '{4, 2, 1, 2, 1};
  int          pt[5]  = '{0, 1, 1, 2, 0};
  int          pf[5]  = '{0, 4, 3, 5, 2};
  int          pcw[5] = '{3, 3, 4, 3, 5};
  logic [15:0] psi[5] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'hBEEF};

  logic [15:0] mq[5];
  int          mrem[5];
  bit          mbusy[5];
  bit          mdone[5];
  int          n_checks = 0;
  int          n_err = 0;
  logic [15:0] qh;

  always #5 clk = ~clk;

  c_shift_lane_v5_0 #(.C_WIDTH(16), .C_LANE(4), .C_SHIFT_TYPE(0), .C_FILL_DATA(0)) u0 (
    .CLK(clk), .ACLR_N(aclr_n), .CE(ce), .SCLR(sclr), .LSB_2_MSB(lsb2msb), .P_LOAD(pload),
    .D(d), .SDIN(sdin), .SHIFT(shift), .START(start), .COUNT(cnt[2:0]),
    .BUSY(busy[0]), .DONE(done[0]), .SDOUT(s0), .Q(q0));
  c_shift_lane_v5_0 #(.C_WIDTH(8), .C_LANE(2), .C_SHIFT_TYPE(1), .C_FILL_DATA(4)) u1 (
    .CLK(clk), .ACLR_N(aclr_n), .CE(ce), .SCLR(sclr), .LSB_2_MSB(lsb2msb), .P_LOAD(pload),
    .D(d[7:0]), .SDIN(sdin[1:0]), .SHIFT(shift), .START(start), .COUNT(cnt[2:0]),
    .BUSY(busy[1]), .DONE(done[1]), .SDOUT(s1), .Q(q1));
  c_shift_lane_v5_0 #(.C_WIDTH(8), .C_LANE(1), .C_SHIFT_TYPE(1), .C_FILL_DATA(3)) u2 (
    .CLK(clk), .ACLR_N(aclr_n), .CE(ce), .SCLR(sclr), .LSB_2_MSB(lsb2msb), .P_LOAD(pload),
    .D(d[7:0]), .SDIN(sdin[0:0]), .SHIFT(shift), .START(start), .COUNT(cnt[3:0]),
    .BUSY(busy[2]), .DONE(done[2]), .SDOUT(s2), .Q(q2));
  c_shift_lane_v5_0 #(.C_WIDTH(8), .C_LANE(2), .C_SHIFT_TYPE(2), .C_FILL_DATA(5)) u3 (
    .CLK(clk), .ACLR_N(aclr_n), .CE(ce), .SCLR(sclr), .LSB_2_MSB(lsb2msb), .P_LOAD(pload),
    .D(d[7:0]), .SDIN(sdin[1:0]), .SHIFT(shift), .START(start), .COUNT(cnt[2:0]),
    .BUSY(busy[3]), .DONE(done[3]), .SDOUT(s3), .Q(q3));
  c_shift_lane_v5_0 #(.C_WIDTH(16), .C_LANE(1), .C_SHIFT_TYPE(0), .C_FILL_DATA(2),
                      .C_SINIT_VAL(16'hBEEF)) u4 (
    .CLK(clk), .ACLR_N(aclr_n), .CE(ce), .SCLR(sclr), .LSB_2_MSB(lsb2msb), .P_LOAD(pload),
    .D(d), .SDIN(sdin[0:0]), .SHIFT(shift), .START(start), .COUNT(cnt[4:0]),
    .BUSY(busy[4]), .DONE(done[4]), .SDOUT(s4), .Q(q4));

  function automatic logic [15:0] get_q(int i);
    case (i)
      0: return q0;
      1: return {8'h0, q1};
      2: return {8'h0, q2};
      3: return {8'h0, q3};
      default: return q4;
    endcase
  endfunction

  function automatic logic [15:0] get_s(int i);
    case (i)
      0: return {12'h0, s0};
      1: return {14'h0, s1};
      2: return {15'h0, s2};
      3: return {14'h0, s3};
      default: return {15'h0, s4};
    endcase
  endfunction

  function automatic int m_up(int i);
    if (pt[i] == 0) return 1;
    if (pt[i] == 1) return 0;
    return int'(lsb2msb);
  endfunction

  function automatic logic [15:0] m_sdout(int i);
    int q, lm;
    q  = int'(mq[i]);
    lm = (1 << pl[i]) - 1;
    return 16'((m_up(i) != 0) ? ((q >> (pw[i] - pl[i])) & lm) : (q & lm));
  endfunction

  // Next register value after one lane step, written as plain shifts and masks.
  function automatic logic [15:0] m_step(int i);
    int w, l, lm, wm, q, f, outl;
    w = pw[i]; l = pl[i];
    lm = (1 << l) - 1; wm = (1 << w) - 1;
    q = int'(mq[i]);
    outl = int'(m_sdout(i));
    case (pf[i])
      0: f = 0;
      1: f = lm;
      2: f = ((q & 1) != 0) ? lm : 0;
      3: f = (((q >> (w - 1)) & 1) != 0) ? lm : 0;
      4: f = outl;
      default: f = int'(sdin) & lm;
    endcase
    if (m_up(i) != 0) return 16'(((q << l) | f) & wm);
    return 16'((q >> l) | (f << (w - l)));
  endfunction

  task automatic m_launch(int i, int c);
    int steps;
    steps = pw[i] / pl[i];
    if (c == 0) mdone[i] = 1'b1;
    else begin
      mrem[i]  = (c > steps) ? steps : c;
      mbusy[i] = 1'b1;
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 5; i++) begin
      mq[i] = '0; mrem[i] = 0; mbusy[i] = 1'b0; mdone[i] = 1'b0;
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic m_cycle();
    logic [15:0] nq;
    int c;
    if (!ce) return;
    for (int i = 0; i < 5; i++) begin
      nq = m_step(i);
      c  = int'(cnt) & ((1 << pcw[i]) - 1);
      if (sclr) begin
        mq[i] = psi[i]; mbusy[i] = 1'b0; mrem[i] = 0; mdone[i] = 1'b0;
      end else begin
        mdone[i] = 1'b0;
        if (pload) begin
          mq[i] = d & 16'((1 << pw[i]) - 1);
          if (mbusy[i]) begin mbusy[i] = 1'b0; mrem[i] = 0; end
          else if (start) m_launch(i, c);
        end else if (mbusy[i]) begin
          mq[i] = nq;
          mrem[i]--;
          if (mrem[i] == 0) begin mbusy[i] = 1'b0; mdone[i] = 1'b1; end
        end else begin
          if (start) m_launch(i, c);
          if (shift) mq[i] = nq;
        end
      end
    end
  endtask

  task automatic check(input string tag, input int inst, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s u%0d observed=%h expected=%h", tag, inst, got, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 5; i++) begin
      check("q", i, get_q(i), mq[i]);
      check("busy", i, 16'(busy[i]), 16'(mbusy[i]));
      check("done", i, 16'(done[i]), 16'(mdone[i]));
      check("sdout", i, get_s(i), m_sdout(i));
    end
  endtask

  task automatic tick();
    m_cycle();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic quiet();
    pload = 1'b0; start = 1'b0; shift = 1'b0; sclr = 1'b0;
  endtask

  initial begin
    aclr_n = 1'b0; ce = 1'b1; lsb2msb = 1'b0;
    d = '0; sdin = '0; cnt = '0;
    quiet();
    m_reset();
    #3;
    check_all();
    #4 aclr_n = 1'b1;

    // Load-and-serialize: four 4-bit lanes leave MSB first, zeros fill in.
    pload = 1'b1; start = 1'b1; d = 16'h1234; cnt = 5'd4;
    tick();
    check("ser_q", 0, q0, 16'h1234);
    check("ser_busy", 0, 16'(busy[0]), 16'h1);
    quiet();
    for (int k = 2; k <= 4; k++) begin
      check("ser_sdout", 0, 16'(s0), 16'(k - 1));
      tick();
    end
    check("ser_sdout", 0, 16'(s0), 16'h4);
    tick();
    check("ser_end_q", 0, q0, 16'h0000);
    check("ser_done", 0, 16'(done[0]), 16'h1);
    check("ser_busy_end", 0, 16'(busy[0]), 16'h0);
    tick();
    check("ser_done_pulse", 0, 16'(done[0]), 16'h0);

    // Rotate by one lane, then an over-long count clamps to a full rotation.
    pload = 1'b1; d = 16'h00C6;
    tick();
    quiet(); start = 1'b1; cnt = 5'd1;
    tick();
    quiet();
    tick();
    check("wrap_q", 1, {8'h0, q1}, 16'h00B1);
    check("wrap_done", 1, 16'(done[1]), 16'h1);
    start = 1'b1; cnt = 5'd15;
    tick();
    quiet();
    repeat (4) tick();
    check("clamp_q", 1, {8'h0, q1}, 16'h00B1);
    check("clamp_done", 1, 16'(done[1]), 16'h1);

    // Arithmetic right shift by manual steps; load also aborts running bursts.
    pload = 1'b1; d = 16'h0090;
    tick();
    quiet(); shift = 1'b1;
    repeat (3) tick();
    check("asr_q", 2, {8'h0, q2}, 16'h00F2);
    check("asr_busy", 2, 16'(busy[2]), 16'h0);
    check("asr_done", 2, 16'(done[2]), 16'h0);
    quiet();

    // Freeze a burst with CE, abort it with a load, then a zero-length burst.
    start = 1'b1; cnt = 5'd4;
    tick();
    quiet();
    tick();
    qh = {8'h0, q1};
    ce = 1'b0;
    tick();
    tick();
    check("ce_hold_q", 1, {8'h0, q1}, qh);
    check("ce_hold_busy", 1, 16'(busy[1]), 16'h1);
    ce = 1'b1; pload = 1'b1; d = 16'h000F;
    tick();
    check("abort_q", 1, {8'h0, q1}, 16'h000F);
    check("abort_busy", 1, 16'(busy[1]), 16'h0);
    quiet();
    tick();
    check("abort_no_done", 1, 16'(done[1]), 16'h0);
    start = 1'b1; cnt = 5'd0;
    tick();
    check("zero_done", 1, 16'(done[1]), 16'h1);
    check("zero_q", 1, {8'h0, q1}, 16'h000F);
    quiet();
    tick();
    check("zero_done_pulse", 1, 16'(done[1]), 16'h0);

    // Bidirectional with serial input, direction chosen per step.
    sclr = 1'b1;
    tick();
    check("sclr_q", 4, q4, 16'hBEEF);
    quiet(); shift = 1'b1; sdin = 4'h3; lsb2msb = 1'b1;
    tick();
    check("bidir_up", 3, {8'h0, q3}, 16'h0003);
    sdin = 4'h1; lsb2msb = 1'b0;
    tick();
    check("bidir_dn", 3, {8'h0, q3}, 16'h0040);
    quiet();

    // Asynchronous reset in the middle of a burst, checked without a clock edge.
    pload = 1'b1; d = 16'hA5A5;
    tick();
    quiet(); start = 1'b1; cnt = 5'd5;
    tick();
    quiet();
    tick();
    tick();
    check("pre_rst_busy", 4, 16'(busy[4]), 16'h1);
    #2 aclr_n = 1'b0;
    #1;
    m_reset();
    check("rst_q", 4, q4, 16'h0000);
    check("rst_busy", 4, 16'(busy[4]), 16'h0);
    check("rst_done", 4, 16'(done[4]), 16'h0);
    check_all();
    #2 aclr_n = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      ce      = ($urandom_range(0, 9) != 0);
      sclr    = ($urandom_range(0, 29) == 0);
      pload   = ($urandom_range(0, 9) == 0);
      start   = ($urandom_range(0, 5) == 0);
      shift   = ($urandom_range(0, 2) == 0);
      lsb2msb = 1'($urandom);
      cnt     = 5'($urandom);
      d       = 16'($urandom);
      sdin    = 4'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
